// File: rtl/lut_driver_if.sv
// Request/response port between system logic and the lookup-table controller.
// Valid/ready: a request transfers on a rising edge where reqValid and reqReady are both 1; rspValid is a one-cycle strobe with no backpressure.
interface lut_driver_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              rspValid;
    logic [DATA_W-1:0] rspData;
    logic [ADDR_W-1:0] rspAddr;
    logic              initDone;
    logic              dbgState;

    modport master (
        output reqValid, reqWrite, reqAddr, reqData,
        input  reqReady, rspValid, rspData, rspAddr, initDone, dbgState
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqData,
        output reqReady, rspValid, rspData, rspAddr, initDone, dbgState
    );
endinterface

// File: rtl/lut_driver.sv
// Initiator-side controller for the lookup table: clears the table after reset,
// then serves single read/write requests with fully pipelined read returns.
module lut_driver #(
    parameter int               ADDR_W   = 4,
    parameter int               DATA_W   = 4,
    parameter int               RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    lut_driver_if.slave       bus,
    output logic [ADDR_W-1:0] addrW,
    output logic [ADDR_W-1:0] addrR,
    output logic              WE,
    output logic              RE,
    output logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] dataOut
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] CNT_ONE = 1;

    state_t            r_state;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W-1:0] r_addr_w;
    logic [ADDR_W-1:0] r_addr_r;
    logic              r_we;
    logic              r_re;
    logic [DATA_W-1:0] r_data_in;
    logic              r_req_ready;
    logic              r_init_done;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [RD_LAT:0]   r_pv;
    logic [ADDR_W-1:0] r_pa [RD_LAT+1];

    logic w_wr_acc;
    logic w_rd_acc;

    assign w_wr_acc = bus.reqValid & r_req_ready & bus.reqWrite;
    assign w_rd_acc = bus.reqValid & r_req_ready & ~bus.reqWrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_addr_w    <= '0;
            r_addr_r    <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_data_in   <= '0;
            r_req_ready <= 1'b0;
            r_init_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
            r_pv        <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                r_pa[k] <= '0;
            end
        end else begin
            // Stage RD_LAT lines up with the edge where the table's dataOut is settled.
            r_pv    <= {r_pv[RD_LAT-1:0], w_rd_acc};
            r_pa[0] <= bus.reqAddr;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_pa[k] <= r_pa[k-1];
            end
            r_rsp_valid <= r_pv[RD_LAT];
            if (r_pv[RD_LAT]) begin
                r_rsp_data <= dataOut;
                r_rsp_addr <= r_pa[RD_LAT];
            end

            case (r_state)
                ST_INIT: begin
                    if (!r_cnt[ADDR_W]) begin
                        r_we      <= 1'b1;
                        r_addr_w  <= r_cnt[ADDR_W-1:0];
                        r_data_in <= INIT_VAL;
                        r_cnt     <= r_cnt + CNT_ONE;
                    end else begin
                        r_we        <= 1'b0;
                        r_init_done <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    r_we <= w_wr_acc;
                    r_re <= w_rd_acc;
                    if (w_wr_acc) begin
                        r_addr_w  <= bus.reqAddr;
                        r_data_in <= bus.reqData;
                    end
                    if (w_rd_acc) begin
                        r_addr_r <= bus.reqAddr;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign addrW        = r_addr_w;
    assign addrR        = r_addr_r;
    assign WE           = r_we;
    assign RE           = r_re;
    assign dataIn       = r_data_in;
    assign bus.reqReady = r_req_ready;
    assign bus.rspValid = r_rsp_valid;
    assign bus.rspData  = r_rsp_data;
    assign bus.rspAddr  = r_rsp_addr;
    assign bus.initDone = r_init_done;
    assign bus.dbgState = r_state;
endmodule
